// File: rtl/axis_boxcar_fir_mc.sv
// Multi-channel boxcar (moving-average) FIR with a runtime power-of-two window,
// output decimation and an AXI-Stream master output with a sticky overrun flag.
module axis_boxcar_fir_mc #(
  parameter int CH        = 2,
  parameter int DW_IN     = 32,
  parameter int DW_OUT    = 32,
  parameter int LEN_L_MAX = 6,
  parameter int DECI_W    = 16,
  localparam int LW       = $clog2(LEN_L_MAX + 1)
) (
  input  logic                   a_clk,
  input  logic                   a_reset,
  input  logic [LW-1:0]          len_l,
  input  logic [DECI_W-1:0]      deci,
  input  logic                   next_dv,
  input  logic [CH*DW_IN-1:0]    S_AXIS_tdata,
  input  logic                   S_AXIS_tvalid,
  output logic [CH*DW_OUT-1:0]   M_AXIS_tdata,
  output logic                   M_AXIS_tvalid,
  input  logic                   M_AXIS_tready,
  output logic                   overrun
);

  localparam int DEPTH = 2 ** LEN_L_MAX;
  localparam int AW    = LEN_L_MAX;
  localparam int FW    = LEN_L_MAX + 1;
  localparam int SW    = DW_IN + LEN_L_MAX;

  function automatic logic [SW-1:0] sx(input logic [DW_IN-1:0] v);
    return {{LEN_L_MAX{v[DW_IN-1]}}, v};
  endfunction

  logic [CH*DW_IN-1:0]       ring_r [DEPTH];
  logic [AW-1:0]             wp_r;
  logic [FW-1:0]             fill_r;
  logic [DECI_W-1:0]         dcnt_r;
  logic [LW-1:0]             len_q_r;
  logic [DECI_W-1:0]         deci_q_r;
  logic signed [SW-1:0]      sum_r   [CH];
  logic                      s1_vld_r;

  logic [LW-1:0]             len_c_s;
  logic [FW-1:0]             win_s;
  logic                      accept_s;
  logic                      restart_s;
  logic [FW-1:0]             fill_b_s;
  logic [FW-1:0]             fill_n_s;
  logic                      old_en_s;
  logic [AW-1:0]             rd_idx_s;
  logic [CH*DW_IN-1:0]       ring_rd_s;
  logic [DECI_W-1:0]         dmax_s;
  logic [DECI_W-1:0]         dcnt_b_s;
  logic [DECI_W-1:0]         dcnt_n_s;
  logic                      emit_s;
  logic signed [SW-1:0]      sum_n_s [CH];
  logic signed [SW-1:0]      rnd_s;
  logic signed [DW_IN-1:0]   rt_s    [CH];
  logic [CH*DW_OUT-1:0]      out_s;
  logic                      load_s;

  // Window clamp, accept qualification and restart detection on config change
  always_comb begin
    if (len_l > LW'(LEN_L_MAX)) begin
      len_c_s = LW'(LEN_L_MAX);
    end else begin
      len_c_s = len_l;
    end
    win_s     = FW'(1) << len_c_s;
    accept_s  = S_AXIS_tvalid & next_dv;
    restart_s = (len_c_s != len_q_r) || (deci != deci_q_r);
    rd_idx_s  = wp_r - win_s[AW-1:0];
    ring_rd_s = ring_r[rd_idx_s];
  end

  // Fill tracking and decimation counter; a restart folds into the same cycle
  always_comb begin
    fill_b_s = restart_s ? '0 : fill_r;
    dcnt_b_s = restart_s ? '0 : dcnt_r;
    old_en_s = (fill_b_s == win_s);
    dmax_s   = (deci > DECI_W'(1)) ? (deci - DECI_W'(1)) : '0;
    if (accept_s) begin
      if (old_en_s) begin
        fill_n_s = fill_b_s;
      end else begin
        fill_n_s = fill_b_s + FW'(1);
      end
    end else begin
      fill_n_s = fill_b_s;
    end
    emit_s   = 1'b0;
    dcnt_n_s = dcnt_b_s;
    if (accept_s && (fill_n_s == win_s)) begin
      if (dcnt_b_s >= dmax_s) begin
        emit_s   = 1'b1;
        dcnt_n_s = '0;
      end else begin
        dcnt_n_s = dcnt_b_s + DECI_W'(1);
      end
    end else begin
      dcnt_n_s = dcnt_b_s;
    end
  end

  // Running sums: add the newest sample, drop the one leaving the window
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum_n_s[c] = restart_s ? '0 : sum_r[c];
      if (accept_s) begin
        if (old_en_s) begin
          sum_n_s[c] = sum_n_s[c] + sx(S_AXIS_tdata[c*DW_IN +: DW_IN])
                                  - sx(ring_rd_s[c*DW_IN +: DW_IN]);
        end else begin
          sum_n_s[c] = sum_n_s[c] + sx(S_AXIS_tdata[c*DW_IN +: DW_IN]);
        end
      end else begin
        sum_n_s[c] = sum_n_s[c];
      end
    end
  end

  // Round-half-up divide by the registered window; result always fits DW_IN
  always_comb begin
    if (len_q_r == '0) begin
      rnd_s = '0;
    end else begin
      rnd_s = SW'(1) << (len_q_r - LW'(1));
    end
    for (int c = 0; c < CH; c++) begin
      rt_s[c] = DW_IN'((sum_r[c] + rnd_s) >>> len_q_r);
    end
    load_s = s1_vld_r && !restart_s;
  end

  for (genvar g = 0; g < CH; g++) begin : g_out
    if (DW_OUT >= DW_IN) begin : g_ext
      assign out_s[g*DW_OUT +: DW_OUT] = DW_OUT'(rt_s[g]);
    end else begin : g_trunc
      assign out_s[g*DW_OUT +: DW_OUT] = rt_s[g][DW_IN-1 -: DW_OUT];
    end
  end

  // Sample ring; never cleared because fill gates every read
  always_ff @(posedge a_clk) begin
    if (accept_s) begin
      ring_r[wp_r] <= S_AXIS_tdata;
    end
  end

  // Filter state, stage-1 valid and AXIS output register
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      wp_r          <= '0;
      fill_r        <= '0;
      dcnt_r        <= '0;
      len_q_r       <= '0;
      deci_q_r      <= '0;
      s1_vld_r      <= 1'b0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      overrun       <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        sum_r[c] <= '0;
      end
    end else begin
      len_q_r  <= len_c_s;
      deci_q_r <= deci;
      fill_r   <= fill_n_s;
      dcnt_r   <= dcnt_n_s;
      s1_vld_r <= emit_s;
      if (accept_s) begin
        wp_r <= wp_r + AW'(1);
      end
      for (int c = 0; c < CH; c++) begin
        sum_r[c] <= sum_n_s[c];
      end
      if (load_s) begin
        M_AXIS_tdata  <= out_s;
        M_AXIS_tvalid <= 1'b1;
        if (M_AXIS_tvalid && !M_AXIS_tready) begin
          overrun <= 1'b1;
        end
      end else if (M_AXIS_tvalid && M_AXIS_tready) begin
        M_AXIS_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_boxcar_fir_mc.sv
// Scoreboard bench for axis_boxcar_fir_mc: a sample-history model predicts
// every emitted average; per-scenario tasks add targeted timing/flag checks.
module tb_axis_boxcar_fir_mc;

  logic        a_clk;
  logic        a_reset;
  logic [2:0]  len_l;
  logic [15:0] deci;
  logic        next_dv;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic        overrun;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          n_out  = 0;
  logic [31:0] exp_q[$];
  int          h0[$];
  int          h1[$];
  int          m_len, m_deci, m_dcnt;
  int          cfg_len  = 0;
  int          cfg_deci = 1;
  bit          rdy      = 1'b1;
  bit          sb_en    = 1'b1;

  axis_boxcar_fir_mc #(
    .CH(2), .DW_IN(16), .DW_OUT(16), .LEN_L_MAX(4), .DECI_W(16)
  ) dut (
    .a_clk(a_clk), .a_reset(a_reset), .len_l(len_l), .deci(deci),
    .next_dv(next_dv), .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready), .overrun(overrun)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  // Scoreboard: every completed output handshake is popped and compared
  always @(negedge a_clk) begin
    if (!a_reset && sb_en && M_AXIS_tvalid && M_AXIS_tready) begin
      logic [31:0] e;
      n_vec++;
      n_out++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL sb_unexpected got=%h exp=none", M_AXIS_tdata);
      end else begin
        e = exp_q.pop_front();
        if (M_AXIS_tdata !== e) begin
          n_miss++;
          $display("FAIL sb_data got=%h exp=%h", M_AXIS_tdata, e);
        end
      end
    end
  end

  task automatic drive(input bit v, input bit dv, input int x0, input int x1);
    int lc, lw, dm;
    longint s0, s1, e0, e1;
    logic [15:0] a, b;
    @(posedge a_clk); #1;
    len_l = 3'(cfg_len);
    deci  = 16'(cfg_deci);
    S_AXIS_tvalid = v;
    next_dv = dv;
    a = x0[15:0];
    b = x1[15:0];
    S_AXIS_tdata = {b, a};
    M_AXIS_tready = rdy;
    lc = (cfg_len > 4) ? 4 : cfg_len;
    lw = 1 << lc;
    if (lc != m_len || cfg_deci != m_deci) begin
      h0.delete(); h1.delete();
      m_dcnt = 0; m_len = lc; m_deci = cfg_deci;
    end
    if (v && dv) begin
      h0.push_back(x0);
      h1.push_back(x1);
      if (h0.size() > lw) begin
        void'(h0.pop_front());
        void'(h1.pop_front());
      end
      if (h0.size() == lw) begin
        dm = (cfg_deci > 1) ? cfg_deci - 1 : 0;
        if (m_dcnt == dm) begin
          s0 = 0; s1 = 0;
          foreach (h0[i]) begin
            s0 += h0[i];
            s1 += h1[i];
          end
          e0 = (s0 + (lw >> 1)) >>> lc;
          e1 = (s1 + (lw >> 1)) >>> lc;
          if (sb_en) exp_q.push_back({e1[15:0], e0[15:0]});
          m_dcnt = 0;
        end else begin
          m_dcnt++;
        end
      end
    end
  endtask

  task automatic reset_pulse();
    @(posedge a_clk); #1;
    a_reset = 1'b1;
    S_AXIS_tvalid = 1'b0;
    @(posedge a_clk); #1;
    a_reset = 1'b0;
    h0.delete(); h1.delete();
    m_len = 0; m_deci = 0; m_dcnt = 0;
    exp_q.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    a_reset = 1'b1; len_l = 3'd0; deci = 16'd1; next_dv = 1'b0;
    S_AXIS_tdata = 32'd0; S_AXIS_tvalid = 1'b0; M_AXIS_tready = 1'b1;
    m_len = 0; m_deci = 0; m_dcnt = 0;
    repeat (3) @(posedge a_clk);
    #1;
    n_vec += 3;
    if (M_AXIS_tvalid !== 1'b0) begin n_miss++; $display("FAIL reset_tvalid got=%b exp=0", M_AXIS_tvalid); end
    if (M_AXIS_tdata !== 32'd0) begin n_miss++; $display("FAIL reset_tdata got=%h exp=0", M_AXIS_tdata); end
    if (overrun !== 1'b0) begin n_miss++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    a_reset = 1'b0;
  endtask

  task automatic test_steady();
    cfg_len = 2; cfg_deci = 1; rdy = 1'b1; sb_en = 1'b1;
    reset_pulse();
    repeat (4) drive(1'b1, 1'b1, 100, -100);
    drive(1'b1, 1'b1, 100, -100);
    n_vec++;
    if (M_AXIS_tvalid !== 1'b0) begin n_miss++; $display("FAIL steady_lat1 got=%b exp=0", M_AXIS_tvalid); end
    drive(1'b1, 1'b1, 100, -100);
    n_vec += 2;
    if (M_AXIS_tvalid !== 1'b1) begin n_miss++; $display("FAIL steady_lat2 got=%b exp=1", M_AXIS_tvalid); end
    if (M_AXIS_tdata !== 32'hFF9C_0064) begin n_miss++; $display("FAIL steady_first got=%h exp=ff9c0064", M_AXIS_tdata); end
    repeat (4) drive(1'b1, 1'b1, 100, -100);
    drain(4);
  endtask

  task automatic test_rounding();
    cfg_len = 2; cfg_deci = 1;
    reset_pulse();
    drive(1'b1, 1'b1, 1, -1);
    drive(1'b1, 1'b1, 2, -2);
    drive(1'b1, 1'b1, 3, -3);
    drive(1'b1, 1'b1, 3, -3);
    drive(1'b1, 1'b1, 7, -7);
    drain(4);
  endtask

  task automatic test_extremes();
    cfg_len = 4; cfg_deci = 1;
    reset_pulse();
    for (int i = 0; i < 40; i++) drive((i % 3) != 2, (i % 5) != 4, 32767, -32768);
    cfg_len = 7;
    for (int i = 0; i < 40; i++) drive((i % 3) != 1, (i % 5) != 3, -32768, 32767);
    drain(4);
  endtask

  task automatic test_decimation();
    int n0;
    cfg_len = 0; cfg_deci = 4;
    reset_pulse();
    n0 = n_out;
    for (int i = 1; i <= 12; i++) drive(1'b1, 1'b1, i, -i);
    drain(4);
    n_vec++;
    if (n_out - n0 != 3) begin n_miss++; $display("FAIL deci_count got=%0d exp=3", n_out - n0); end
  endtask

  task automatic test_backpressure();
    cfg_len = 0; cfg_deci = 1; sb_en = 1'b0; rdy = 1'b0;
    reset_pulse();
    drive(1'b1, 1'b1, 5, 6);
    drive(1'b1, 1'b1, 9, 10);
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    n_vec += 3;
    if (M_AXIS_tdata !== 32'h000A_0009) begin n_miss++; $display("FAIL bp_hold got=%h exp=000a0009", M_AXIS_tdata); end
    if (M_AXIS_tvalid !== 1'b1) begin n_miss++; $display("FAIL bp_tvalid got=%b exp=1", M_AXIS_tvalid); end
    if (overrun !== 1'b1) begin n_miss++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
    rdy = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    n_vec += 2;
    if (M_AXIS_tvalid !== 1'b0) begin n_miss++; $display("FAIL bp_release got=%b exp=0", M_AXIS_tvalid); end
    if (overrun !== 1'b1) begin n_miss++; $display("FAIL bp_sticky got=%b exp=1", overrun); end
    rdy = 1'b0;
    reset_pulse();
    n_vec++;
    if (overrun !== 1'b0) begin n_miss++; $display("FAIL bp_rst_overrun got=%b exp=0", overrun); end
    drive(1'b1, 1'b1, 3, 4);
    drive(1'b1, 1'b1, 7, 8);
    rdy = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    n_vec += 3;
    if (M_AXIS_tdata !== 32'h0008_0007) begin n_miss++; $display("FAIL bp_swap got=%h exp=00080007", M_AXIS_tdata); end
    if (M_AXIS_tvalid !== 1'b1) begin n_miss++; $display("FAIL bp_swap_tvalid got=%b exp=1", M_AXIS_tvalid); end
    if (overrun !== 1'b0) begin n_miss++; $display("FAIL bp_no_overrun got=%b exp=0", overrun); end
    drive(1'b0, 1'b0, 0, 0);
    n_vec++;
    if (M_AXIS_tvalid !== 1'b0) begin n_miss++; $display("FAIL bp_drop got=%b exp=0", M_AXIS_tvalid); end
    sb_en = 1'b1;
  endtask

  task automatic test_reset_reconfig();
    int n0;
    cfg_len = 2; cfg_deci = 1; rdy = 1'b1; sb_en = 1'b1;
    reset_pulse();
    drive(1'b1, 1'b1, 1, -1);
    drive(1'b1, 1'b1, 2, -2);
    drive(1'b1, 1'b1, 3, -3);
    reset_pulse();
    n_vec++;
    if (M_AXIS_tvalid !== 1'b0) begin n_miss++; $display("FAIL rr_tvalid got=%b exp=0", M_AXIS_tvalid); end
    repeat (3) drive(1'b1, 1'b1, 40, -40);
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    n_vec++;
    if (M_AXIS_tvalid !== 1'b0) begin n_miss++; $display("FAIL rr_early got=%b exp=0", M_AXIS_tvalid); end
    drive(1'b1, 1'b1, 40, -40);
    drain(4);
    drive(1'b1, 1'b1, 8, -8);
    drive(1'b1, 1'b1, 8, -8);
    drain(4);
    n0 = n_out;
    cfg_len = 1;
    drive(1'b1, 1'b1, 10, -3);
    drive(1'b1, 1'b1, 30, -4);
    drain(4);
    n_vec++;
    if (n_out - n0 != 1) begin n_miss++; $display("FAIL rr_len_count got=%0d exp=1", n_out - n0); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_rounding();
    test_extremes();
    test_decimation();
    test_backpressure();
    test_reset_reconfig();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
